// File: rtl/instruction_fetch_stage.sv
// Fetch stage: issues PC requests to a 1-cycle synchronous instruction memory and
// queues {instruction, pc} pairs in a small credit-controlled FIFO toward decode.
module instruction_fetch_stage #(
    parameter int ADDR_W     = 8,
    parameter int INSTR_W    = 32,
    parameter int FIFO_DEPTH = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_address,
    input  logic               pc_valid,
    output logic               pc_ready,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               flush,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               if_valid,
    input  logic               id_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Wide enough to hold count plus the in-flight credit without overflow.
    localparam int CNT_W = $clog2(FIFO_DEPTH + 2);

    logic [CNT_W-1:0]   count_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic               inflight_r;
    logic [ADDR_W-1:0]  inflight_pc_r;
    logic               run_r;
    logic [INSTR_W-1:0] mem_instr_r [FIFO_DEPTH];
    logic [ADDR_W-1:0]  mem_pc_r    [FIFO_DEPTH];

    logic [CNT_W-1:0]   occupancy_s;
    logic               pc_ready_s;
    logic               accept_s;
    logic               push_s;
    logic               pop_s;
    logic               if_valid_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            ptr_inc = {PTR_W{1'b0}};
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    // Handshake decode; ready depends only on registered occupancy and flush.
    always_comb begin
        occupancy_s = count_r + CNT_W'(inflight_r);
        pc_ready_s  = run_r & ~flush & (occupancy_s < CNT_W'(FIFO_DEPTH));
        accept_s    = pc_valid & pc_ready_s;
        push_s      = inflight_r & ~flush;
        if_valid_s  = (count_r != {CNT_W{1'b0}});
        pop_s       = if_valid_s & id_ready & ~flush;
    end

    // Output drive.
    always_comb begin
        pc_ready  = pc_ready_s;
        imem_en   = accept_s;
        imem_addr = pc_address;
        if_valid  = if_valid_s;
        if_instr  = mem_instr_r[rd_ptr_r];
        if_pc     = mem_pc_r[rd_ptr_r];
    end

    // Holds pc_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // Tracks the single outstanding memory read and its PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_r    <= 1'b0;
            inflight_pc_r <= {ADDR_W{1'b0}};
        end else if (flush) begin
            inflight_r    <= 1'b0;
        end else begin
            inflight_r <= accept_s;
            if (accept_s) begin
                inflight_pc_r <= pc_address;
            end
        end
    end

    // FIFO pointers and occupancy; flush overrides push and pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r  <= {CNT_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else if (flush) begin
            count_r  <= {CNT_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero when empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_instr_r[i] <= {INSTR_W{1'b0}};
                mem_pc_r[i]    <= {ADDR_W{1'b0}};
            end
        end else if (push_s) begin
            mem_instr_r[wr_ptr_r] <= imem_rdata;
            mem_pc_r[wr_ptr_r]    <= inflight_pc_r;
        end else begin
            mem_instr_r[wr_ptr_r] <= mem_instr_r[wr_ptr_r];
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed vector table plus reset and randomized scoreboard sequences for the
// instruction fetch stage.
module tb_instruction_fetch_stage;

    logic        clk;
    logic        reset;
    logic [7:0]  pc_address;
    logic        pc_valid;
    logic        pc_ready;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        flush;
    logic [31:0] if_instr;
    logic [7:0]  if_pc;
    logic        if_valid;
    logic        id_ready;

    int checks = 0;
    int errors = 0;

    instruction_fetch_stage #(.ADDR_W(8), .INSTR_W(32), .FIFO_DEPTH(3)) dut (
        .clk(clk), .reset(reset), .pc_address(pc_address), .pc_valid(pc_valid),
        .pc_ready(pc_ready), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .flush(flush), .if_instr(if_instr), .if_pc(if_pc),
        .if_valid(if_valid), .id_ready(id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: word at addr is 0xA0000000 + addr.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= {24'hA00000, imem_addr};
    end

    typedef struct {
        logic       pv;
        logic [7:0] addr;
        logic       idr;
        logic       fl;
        logic       rdy;
        logic       en;
        logic       vld;
        logic [7:0] pc;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pv, input logic [7:0] addr, input logic idr, input logic fl);
        @(posedge clk);
        #1;
        pc_valid   = pv;
        pc_address = addr;
        id_ready   = idr;
        flush      = fl;
    endtask

    logic [7:0] mq [$];
    logic       m_infl;
    logic [7:0] m_infl_pc;
    logic [7:0] pc_cur;
    logic       exp_rdy;
    logic       acc;

    initial begin
        // pv, addr, idr, fl | rdy, en, vld, pc
        // Streaming PC 0..3 with decode always ready.
        vecs[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00};
        vecs[3]  = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01};
        vecs[4]  = '{1'b0, 8'h04, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02};
        vecs[5]  = '{1'b0, 8'h04, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03};
        vecs[6]  = '{1'b0, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        // Backpressure: three accepts then stall; drain with pointer wrap.
        vecs[7]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[8]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[9]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00};
        vecs[10] = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[11] = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[12] = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[13] = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01};
        vecs[14] = '{1'b0, 8'h04, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02};
        vecs[15] = '{1'b0, 8'h04, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03};
        vecs[16] = '{1'b0, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        // Flush with two entries queued and one read in flight.
        vecs[17] = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[18] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[19] = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10};
        vecs[20] = '{1'b1, 8'h13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10};
        vecs[21] = '{1'b1, 8'h40, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[22] = '{1'b0, 8'h41, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[23] = '{1'b0, 8'h41, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h40};
        vecs[24] = '{1'b0, 8'h41, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

        reset      = 1'b0;
        pc_valid   = 1'b1;
        pc_address = 8'h00;
        id_ready   = 1'b0;
        flush      = 1'b0;
        imem_rdata = 32'h0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_imem_en", {31'b0, imem_en}, 32'h0);
        chk("rst_if_pc", {24'b0, if_pc}, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        pc_valid = 1'b0;

        // Directed vector table.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].pv, vecs[i].addr, vecs[i].idr, vecs[i].fl);
            @(negedge clk);
            chk($sformatf("v%0d_pc_ready", i), {31'b0, pc_ready}, {31'b0, vecs[i].rdy});
            chk($sformatf("v%0d_imem_en", i), {31'b0, imem_en}, {31'b0, vecs[i].en});
            chk($sformatf("v%0d_if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].vld});
            if (vecs[i].en) begin
                chk($sformatf("v%0d_imem_addr", i), {24'b0, imem_addr}, {24'b0, vecs[i].addr});
            end
            if (vecs[i].vld) begin
                chk($sformatf("v%0d_if_pc", i), {24'b0, if_pc}, {24'b0, vecs[i].pc});
                chk($sformatf("v%0d_if_instr", i), if_instr, {24'hA00000, vecs[i].pc});
            end
        end

        // Mid-stream reset with two entries queued.
        drive(1'b1, 8'h20, 1'b0, 1'b0);
        drive(1'b1, 8'h21, 1'b0, 1'b0);
        drive(1'b0, 8'h22, 1'b0, 1'b0);
        drive(1'b0, 8'h22, 1'b0, 1'b0);
        @(negedge clk);
        chk("mid_pre_if_valid", {31'b0, if_valid}, 32'h1);
        chk("mid_pre_if_pc", {24'b0, if_pc}, 32'h20);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        pc_valid = 1'b1;
        #1;
        chk("mid_rst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("mid_rst_imem_en", {31'b0, imem_en}, 32'h0);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        pc_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_post_pc_ready", {31'b0, pc_ready}, 32'h1);
        chk("mid_post_if_valid", {31'b0, if_valid}, 32'h0);

        // Random traffic against a scoreboard model.
        m_infl    = 1'b0;
        m_infl_pc = 8'h00;
        pc_cur    = 8'h00;
        for (int c = 0; c < 1000; c++) begin
            drive($urandom_range(0, 3) != 0, pc_cur, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 49) == 0);
            @(negedge clk);
            exp_rdy = !flush && ((mq.size() + int'(m_infl)) < 3);
            acc     = pc_valid && exp_rdy;
            chk("rnd_pc_ready", {31'b0, pc_ready}, {31'b0, exp_rdy});
            chk("rnd_imem_en", {31'b0, imem_en}, {31'b0, acc});
            chk("rnd_if_valid", {31'b0, if_valid}, {31'b0, mq.size() != 0});
            if (mq.size() != 0) begin
                chk("rnd_if_pc", {24'b0, if_pc}, {24'b0, mq[0]});
                chk("rnd_if_instr", if_instr, {24'hA00000, mq[0]});
            end
            if (flush) begin
                mq.delete();
                m_infl = 1'b0;
            end else begin
                if (mq.size() != 0 && id_ready) void'(mq.pop_front());
                if (m_infl) mq.push_back(m_infl_pc);
                m_infl = acc;
                if (acc) begin
                    m_infl_pc = pc_cur;
                    pc_cur    = pc_cur + 8'd1;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
